keypad_emulator: RTL

//  Emulates the 4x4 matrix keypad on the far side of the column-scan/row-read interface.

---
 rtl/keypad_pkg.sv | 53 +++++
 rtl/keypad_emulator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM states, key matrix lookup and active-low pattern helpers.
// Also imported by the scanning keypad decoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    HOLD,
    GAP
  } state_e;

  typedef struct packed {
    logic [1:0] col_idx;
    logic [1:0] row_idx;
  } key_pos_t;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // Matrix layout, col index -> rows 0..3:
  //   col0: 1 4 7 0 | col1: 2 5 8 F | col2: 3 6 9 E | col3: A B C D
  function automatic key_pos_t key_pos(input logic [3:0] code);
    key_pos_t p;
    p = '0;
    case (code)
      4'h1: p = '{col_idx: 2'd0, row_idx: 2'd0};
      4'h4: p = '{col_idx: 2'd0, row_idx: 2'd1};
      4'h7: p = '{col_idx: 2'd0, row_idx: 2'd2};
      4'h0: p = '{col_idx: 2'd0, row_idx: 2'd3};
      4'h2: p = '{col_idx: 2'd1, row_idx: 2'd0};
      4'h5: p = '{col_idx: 2'd1, row_idx: 2'd1};
      4'h8: p = '{col_idx: 2'd1, row_idx: 2'd2};
      4'hF: p = '{col_idx: 2'd1, row_idx: 2'd3};
      4'h3: p = '{col_idx: 2'd2, row_idx: 2'd0};
      4'h6: p = '{col_idx: 2'd2, row_idx: 2'd1};
      4'h9: p = '{col_idx: 2'd2, row_idx: 2'd2};
      4'hE: p = '{col_idx: 2'd2, row_idx: 2'd3};
      4'hA: p = '{col_idx: 2'd3, row_idx: 2'd0};
      4'hB: p = '{col_idx: 2'd3, row_idx: 2'd1};
      4'hC: p = '{col_idx: 2'd3, row_idx: 2'd2};
      4'hD: p = '{col_idx: 2'd3, row_idx: 2'd3};
      default: p = '0;
    endcase
    return p;
  endfunction

  // Index 0 maps to the MSB being low (0111), index 3 to the LSB (1110).
  function automatic logic [3:0] idx_to_pat(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot = 4'b1000 >> idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: answers the scanner's active-low column drive with the
// active-low row of one requested key, with optional contact bounce, hold and release gap.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYC     = 3_000_000,
  parameter int unsigned GAP_CYC      = 2_000_000,
  parameter int unsigned BOUNCE_EDGES = 0,
  parameter int unsigned BOUNCE_CYC   = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic       abort,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       pressed,
  output logic       done
);

  localparam int unsigned MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned MAX_CYC = (MAX_HG > BOUNCE_CYC) ? MAX_HG : BOUNCE_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] BOUNCE_LD = CW'(BOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [7:0]    BOUNCE_N  = 8'(BOUNCE_EDGES);
  localparam logic          HOLD_ONE  = (HOLD_CYC == 1);

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_bcnt;
  logic [3:0]      r_code;
  logic            r_contact;
  logic            r_done;
  logic [3:0]      r_row;

  logic            w_accept;
  logic            w_cnt_zero;
  logic [7:0]      w_bcnt_inc;
  logic            w_last_bounce;
  logic            w_contact_nxt;
  logic [3:0]      w_code_nxt;
  key_pos_t        w_pos;
  logic [3:0]      w_col_pat;
  logic [3:0]      w_row_pat;

  assign key_ready     = (r_state == IDLE) && !abort;
  assign w_accept      = key_valid && key_ready;
  assign w_cnt_zero    = (r_cnt == '0);
  assign w_bcnt_inc    = r_bcnt + 8'd1;
  assign w_last_bounce = (w_bcnt_inc == BOUNCE_N);

  // Next contact value is shared by the FSM and the row register so that row
  // never asserts on a cycle where pressed is low (toggles, abort, acceptance).
  always_comb begin
    w_contact_nxt = 1'b0;
    case (r_state)
      IDLE:    w_contact_nxt = w_accept;
      BOUNCE: begin
        if (!abort) begin
          w_contact_nxt = w_cnt_zero ? (w_last_bounce || !r_contact) : r_contact;
        end
      end
      HOLD:    w_contact_nxt = !abort && !w_cnt_zero;
      default: w_contact_nxt = 1'b0;
    endcase
  end

  assign w_code_nxt = w_accept ? key_code : r_code;
  assign w_pos      = key_pos(w_code_nxt);
  assign w_col_pat  = idx_to_pat(w_pos.col_idx);
  assign w_row_pat  = idx_to_pat(w_pos.row_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bcnt    <= '0;
      r_code    <= '0;
      r_contact <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_contact <= w_contact_nxt;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_code <= key_code;
            r_bcnt <= '0;
            if (BOUNCE_EDGES > 0) begin
              r_state <= BOUNCE;
              r_cnt   <= BOUNCE_LD;
            end else begin
              r_state <= HOLD;
              r_cnt   <= HOLD_LD;
              r_done  <= HOLD_ONE;
            end
          end
        end
        BOUNCE: begin
          if (abort) begin
            r_state <= GAP;
            r_cnt   <= GAP_LD;
            r_bcnt  <= '0;
            r_done  <= 1'b1;
          end else if (w_cnt_zero) begin
            r_bcnt <= w_bcnt_inc;
            if (w_last_bounce) begin
              r_state <= HOLD;
              r_cnt   <= HOLD_LD;
              r_done  <= HOLD_ONE;
            end else begin
              r_cnt <= BOUNCE_LD;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        HOLD: begin
          if (abort) begin
            r_state <= GAP;
            r_cnt   <= GAP_LD;
            r_bcnt  <= '0;
            r_done  <= 1'b1;
          end else if (w_cnt_zero) begin
            r_state <= GAP;
            r_cnt   <= GAP_LD;
          end else begin
            r_cnt  <= r_cnt - CNT_ONE;
            r_done <= (r_cnt == CNT_ONE);
          end
        end
        GAP: begin
          if (w_cnt_zero) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= ROW_IDLE;
    end else begin
      r_row <= (w_contact_nxt && (col == w_col_pat)) ? w_row_pat : ROW_IDLE;
    end
  end

  assign row     = r_row;
  assign pressed = r_contact;
  assign done    = r_done;

endmodule
